// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dm_responder
//  Description : Single-outstanding data-memory responder. Accepts one
//                request at a time, waits LATENCY cycles, commits the access
//                to a byte-lane-writable word store and presents the response
//                until the initiator takes it. Misaligned or out-of-range
//                addresses return an error and leave the store untouched.
//  Options     : define DM_RESPONDER_TRACE_EN to print one trace line per
//                committed non-error write with a non-zero byte enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] C_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  C_LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          w_accept;
    logic          w_from_req;
    logic          w_commit;
    logic          w_we;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [3:0]    w_be;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_old;
    logic [31:0]   word_d;
    logic          w_mem_we;
    logic [31:0]   w_rsp_rdata;

    // Ready is gated by reset directly so it is low during reset and high in
    // the very first cycle after release, without waiting for a clock edge.
    assign req_ready = (state_q == S_IDLE) && reset;
    assign w_accept  = req_valid && req_ready;

    // With zero latency the access commits on the accept edge itself, so the
    // commit path takes the live request; otherwise it takes the captured one.
    assign w_from_req = (state_q == S_IDLE);
    assign w_we       = w_from_req ? req_we    : we_q;
    assign w_addr     = w_from_req ? req_addr  : addr_q;
    assign w_wdata    = w_from_req ? req_wdata : wdata_q;
    assign w_be       = w_from_req ? req_be    : be_q;

    assign w_commit = (w_from_req && w_accept && (LATENCY == 0)) ||
                      ((state_q == S_WAIT) && (cnt_q == 4'd1));

    assign w_err       = (w_addr[1:0] != 2'b00) || ({1'b0, w_addr} >= C_LIMIT);
    assign w_idx       = w_addr[AW+1:2];
    assign w_old       = mem_q[w_idx];
    assign w_mem_we    = w_commit && w_we && !w_err && (w_be != 4'b0000);
    assign w_rsp_rdata = (w_we || w_err) ? 32'h0 : w_old;

    // Merge enabled write lanes over the currently stored word.
    always_comb begin
        word_d = w_old;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
                word_d[8*i +: 8] = w_wdata[8*i +: 8];
            end
        end
    end

    // Control FSM: request capture, latency countdown, response hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        if (LATENCY == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= C_LAT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= S_RESP;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (w_commit) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= w_rsp_rdata;
                rsp_err_q   <= w_err;
            end
        end
    end

    // Word store: cleared by reset, written only by a committed good write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (w_mem_we) begin
            mem_q[w_idx] <= word_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

`ifdef DM_RESPONDER_TRACE_EN
    logic [31:0] pc_q;
    logic [31:0] w_pc;

    assign w_pc = w_from_req ? req_pc : pc_q;

    // Capture the issuing PC alongside the request for the trace line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= 32'h0;
        end else if (w_accept) begin
            pc_q <= req_pc;
        end
    end

    // Print one line per committed write that actually changes lanes.
    always_ff @(posedge clk) begin
        if (reset && w_mem_we) begin
            $display("%0t@%08h: *%08h <= %08h", $time, w_pc,
                     {w_addr[31:2], 2'b00}, word_d);
        end
    end
`else
    // The PC only feeds the trace, which is compiled out here.
    logic w_unused_pc;
    assign w_unused_pc = ^req_pc;
`endif

endmodule
`default_nettype wire
